// File: rtl/lgn_pkg.sv
// Shared definitions for the logic-gate-network class scorer: default geometry,
// scorer FSM states and the score-width helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package lgn_pkg;

    // Default classifier geometry: ten classes, 256 net output bits each.
    localparam int LGN_CATEGORIES        = 10;
    localparam int LGN_BITS_PER_CATEGORY = 256;
    localparam int LGN_CHUNK             = 32;

    // Scorer sequencing: load/accumulate, arg-max scan, one-cycle result.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        SELECT = 2'd2,
        DONE   = 2'd3
    } lgn_state_t;

    // Bits needed to hold a popcount of 'bits' inputs, including the all-ones
    // value (256 bits needs 9, not 8).
    function automatic int lgn_score_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/lgn_popcount_chunk.sv
// Combinational popcount of a CHUNK-bit word as a balanced adder tree.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: data (CHUNK bits in), count ($clog2(CHUNK+1) bits out).
module lgn_popcount_chunk #(
    parameter int CHUNK = 32
) (
    input  logic [CHUNK-1:0]             data,
    output logic [$clog2(CHUNK+1)-1:0]   count
);

    localparam int CNT_W = $clog2(CHUNK + 1);

    generate
        if (CHUNK == 1) begin : g_leaf
            assign count = data;
        end else begin : g_node
            // Split unevenly when CHUNK is odd; each half recurses down to
            // single bits, so the tree depth is ceil(log2(CHUNK)).
            localparam int LO   = CHUNK / 2;
            localparam int HI   = CHUNK - LO;
            localparam int LO_W = $clog2(LO + 1);
            localparam int HI_W = $clog2(HI + 1);

            logic [LO_W-1:0] lo_cnt;
            logic [HI_W-1:0] hi_cnt;

            lgn_popcount_chunk #(.CHUNK(LO)) u_lo (
                .data  (data[LO-1:0]),
                .count (lo_cnt)
            );

            lgn_popcount_chunk #(.CHUNK(HI)) u_hi (
                .data  (data[CHUNK-1:LO]),
                .count (hi_cnt)
            );

            assign count = CNT_W'(lo_cnt) + CNT_W'(hi_cnt);
        end
    endgenerate

endmodule

// File: rtl/lgn_class_scorer.sv
// Class scorer: snapshots per-class net bits, popcounts CHUNK bits per class per
// cycle, then scans one class per cycle for arg-max, runner-up margin and tie.
// Latency: done is high 19 edges after start is seen at defaults (1 load edge,
// N accumulate edges, CATEGORIES scan edges). Backpressure: none; start is only
// honoured in IDLE or DONE, and ignored (not queued) while busy.
// Ports: clk, rst (async, active high), start, in_bits (class c at
// [c*BPC +: BPC]) in; busy, done, best_index, best_value, margin, tie out.
module lgn_class_scorer
    import lgn_pkg::*;
#(
    parameter int CATEGORIES        = LGN_CATEGORIES,
    parameter int BITS_PER_CATEGORY = LGN_BITS_PER_CATEGORY,
    parameter int CHUNK             = LGN_CHUNK,
    parameter int SCORE_W           = lgn_score_width(BITS_PER_CATEGORY),
    parameter int IDX_W             = (CATEGORIES > 1) ? $clog2(CATEGORIES) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [CATEGORIES*BITS_PER_CATEGORY-1:0] in_bits,
    output logic                                    busy,
    output logic                                    done,
    output logic [IDX_W-1:0]                        best_index,
    output logic [SCORE_W-1:0]                      best_value,
    output logic [SCORE_W-1:0]                      margin,
    output logic                                    tie
);

    localparam int BPC   = BITS_PER_CATEGORY;
    localparam int TOTAL = CATEGORIES * BPC;
    localparam int N     = BPC / CHUNK;
    localparam int PC_W  = $clog2(CHUNK + 1);
    // One counter serves both the chunk phase and the scan phase.
    localparam int CMAX  = (N > CATEGORIES) ? N : CATEGORIES;
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

    lgn_state_t state_q, state_d;
    logic       accept;

    logic [CNT_W-1:0] cnt_q;
    logic             cnt_last_accum;
    logic             cnt_last_sel;

    logic [TOTAL-1:0]                     buf_q;
    logic [CATEGORIES-1:0][SCORE_W-1:0]   acc_q;
    logic [CATEGORIES-1:0][PC_W-1:0]      chunk_cnt;

    logic [SCORE_W-1:0] cur_score;
    logic [SCORE_W-1:0] bv_q, bv_d;
    logic [SCORE_W-1:0] sv_q, sv_d;
    logic [IDX_W-1:0]   bi_q, bi_d;

    assign cnt_last_accum = (cnt_q == CNT_W'(N - 1));
    assign cnt_last_sel   = (cnt_q == CNT_W'(CATEGORIES - 1));

    assign busy = (state_q == ACCUM) || (state_q == SELECT);
    assign done = (state_q == DONE);

    // Per-class popcount of the low chunk still sitting in the shift buffer.
    generate
        for (genvar c = 0; c < CATEGORIES; c++) begin : g_pc
            lgn_popcount_chunk #(.CHUNK(CHUNK)) u_pc (
                .data  (buf_q[c*BPC +: CHUNK]),
                .count (chunk_cnt[c])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (cnt_last_accum) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (cnt_last_sel) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Back-to-back: a start held across DONE launches the next run
                // on this same edge, so no IDLE bubble is inserted.
                if (start) begin
                    accept  = 1'b1;
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Arg-max step for the class selected by the scan counter
    // ------------------------------------------------------------------
    always_comb begin
        cur_score = '0;
        for (int k = 0; k < CATEGORIES; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                cur_score = acc_q[k];
            end
        end

        bv_d = bv_q;
        sv_d = sv_q;
        bi_d = bi_q;
        // Strict compare keeps the lowest index on a tie; the equal score
        // then lands in the runner-up slot, which is what raises tie.
        if (cur_score > bv_q) begin
            sv_d = bv_q;
            bv_d = cur_score;
            bi_d = IDX_W'(cnt_q);
        end else if (cur_score > sv_q) begin
            sv_d = cur_score;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            bv_q       <= '0;
            sv_q       <= '0;
            bi_q       <= '0;
            best_index <= '0;
            best_value <= '0;
            margin     <= '0;
            tie        <= 1'b0;
        end else begin
            if (accept) begin
                buf_q <= in_bits;
                acc_q <= '0;
                cnt_q <= '0;
                bv_q  <= '0;
                sv_q  <= '0;
                bi_q  <= '0;
            end else if (state_q == ACCUM) begin
                for (int c = 0; c < CATEGORIES; c++) begin
                    acc_q[c]              <= acc_q[c] + SCORE_W'(chunk_cnt[c]);
                    buf_q[c*BPC +: BPC]   <= buf_q[c*BPC +: BPC] >> CHUNK;
                end
                // Reset the counter on the way out so the scan starts at 0.
                cnt_q <= cnt_last_accum ? '0 : cnt_q + 1'b1;
            end else if (state_q == SELECT) begin
                bv_q  <= bv_d;
                sv_q  <= sv_d;
                bi_q  <= bi_d;
                cnt_q <= cnt_q + 1'b1;
                // Results are taken from the post-update values so the last
                // class examined is included.
                if (cnt_last_sel) begin
                    best_index <= bi_d;
                    best_value <= bv_d;
                    margin     <= bv_d - sv_d;
                    tie        <= (sv_d == bv_d);
                end
            end
        end
    end

endmodule
